// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Summary  : Two-master round-robin arbiter for the maxicore32 system bus.
//            Registered request/grant handshake. Every change of owner passes
//            through one IDLE cycle. Read data is broadcast to both masters.
// Options  : BUS_ARBITER_PREEMPT_EN - when defined, an owner that has held the
//            bus for MAX_TENURE cycles while the other master waits is forced
//            back to IDLE. When undefined, no tenure counter is built.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int MAX_TENURE = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m1_req,
    output logic        m0_grant,
    output logic        m1_grant,
    input  logic [29:0] m0_address,
    input  logic [29:0] m1_address,
    input  logic [31:0] m0_data_out,
    input  logic [31:0] m1_data_out,
    input  logic [3:0]  m0_data_strobes,
    input  logic [3:0]  m1_data_strobes,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic        m1_read,
    input  logic        m1_write,
    output logic [29:0] address,
    output logic [31:0] data_out,
    output logic [3:0]  data_strobes,
    output logic        read,
    output logic        write,
    input  logic [31:0] data_in,
    output logic [31:0] m0_data_in,
    output logic [31:0] m1_data_in,
    output logic [1:0]  owner
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t      state_q;
    logic        last_owner_q;
    logic        m0_grant_q;
    logic        m1_grant_q;
    logic [1:0]  owner_q;
    logic        preempt0;
    logic        preempt1;

`ifdef BUS_ARBITER_PREEMPT_EN
    localparam int                CNT_W     = $clog2(MAX_TENURE) + 1;
    localparam logic [CNT_W-1:0]  TEN_LAST  = CNT_W'(MAX_TENURE - 1);

    logic [CNT_W-1:0] tenure_q;

    // Forced release: owner has used its full tenure and the other master waits
    assign preempt0 = (tenure_q == TEN_LAST) && m1_req;
    assign preempt1 = (tenure_q == TEN_LAST) && m0_req;
`else
    logic unused_tenure;

    // Without preemption the tenure limit has no effect on the logic
    assign unused_tenure = (MAX_TENURE < 2);
    assign preempt0      = 1'b0;
    assign preempt1      = 1'b0;
`endif

    // Arbitration FSM with registered grant/owner outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            m0_grant_q   <= 1'b0;
            m1_grant_q   <= 1'b0;
            owner_q      <= 2'b00;
`ifdef BUS_ARBITER_PREEMPT_EN
            tenure_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // m0 wins when alone, or on a tie when m1 owned last
                    if (m0_req && (!m1_req || last_owner_q)) begin
                        state_q      <= OWN0;
                        last_owner_q <= 1'b0;
                        m0_grant_q   <= 1'b1;
                        owner_q      <= 2'b01;
                    end else if (m1_req) begin
                        state_q      <= OWN1;
                        last_owner_q <= 1'b1;
                        m1_grant_q   <= 1'b1;
                        owner_q      <= 2'b10;
                    end
`ifdef BUS_ARBITER_PREEMPT_EN
                    tenure_q <= '0;
`endif
                end
                OWN0: begin
                    if (!m0_req || preempt0) begin
                        state_q    <= IDLE;
                        m0_grant_q <= 1'b0;
                        owner_q    <= 2'b00;
                    end
`ifdef BUS_ARBITER_PREEMPT_EN
                    if (tenure_q != TEN_LAST) begin
                        tenure_q <= tenure_q + 1'b1;
                    end
`endif
                end
                OWN1: begin
                    if (!m1_req || preempt1) begin
                        state_q    <= IDLE;
                        m1_grant_q <= 1'b0;
                        owner_q    <= 2'b00;
                    end
`ifdef BUS_ARBITER_PREEMPT_EN
                    if (tenure_q != TEN_LAST) begin
                        tenure_q <= tenure_q + 1'b1;
                    end
`endif
                end
                default: begin
                    state_q    <= IDLE;
                    m0_grant_q <= 1'b0;
                    m1_grant_q <= 1'b0;
                    owner_q    <= 2'b00;
                end
            endcase
        end
    end

    // Shared bus driven by the registered owner only; zero when nobody owns it
    always_comb begin
        address      = '0;
        data_out     = '0;
        data_strobes = '0;
        read         = 1'b0;
        write        = 1'b0;
        case (state_q)
            OWN0: begin
                address      = m0_address;
                data_out     = m0_data_out;
                data_strobes = m0_data_strobes;
                read         = m0_read;
                write        = m0_write;
            end
            OWN1: begin
                address      = m1_address;
                data_out     = m1_data_out;
                data_strobes = m1_data_strobes;
                read         = m1_read;
                write        = m1_write;
            end
            default: begin
            end
        endcase
    end

    assign m0_grant   = m0_grant_q;
    assign m1_grant   = m1_grant_q;
    assign owner      = owner_q;
    assign m0_data_in = data_in;
    assign m1_data_in = data_in;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Summary  : Self-checking bench for bus_arbiter. Directed scenarios followed
//            by randomized traffic, all compared against a behavioural model
//            that tracks the owner and how many cycles it has held the bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int MAX_TENURE = 4;
`ifdef BUS_ARBITER_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        m0_req, m1_req;
    logic        m0_grant, m1_grant;
    logic [29:0] m0_address, m1_address;
    logic [31:0] m0_data_out, m1_data_out;
    logic [3:0]  m0_data_strobes, m1_data_strobes;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [29:0] address;
    logic [31:0] data_out;
    logic [3:0]  data_strobes;
    logic        read, write;
    logic [31:0] data_in;
    logic [31:0] m0_data_in, m1_data_in;
    logic [1:0]  owner;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model: who owns the bus (0 none, 1 m0, 2 m1), who owned last,
    // and how many cycles (including the current one) the owner has held it.
    int mdl_own  = 0;
    int mdl_last = 1;
    int mdl_held = 0;

    bus_arbiter #(.MAX_TENURE(MAX_TENURE)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req),
        .m0_grant(m0_grant), .m1_grant(m1_grant),
        .m0_address(m0_address), .m1_address(m1_address),
        .m0_data_out(m0_data_out), .m1_data_out(m1_data_out),
        .m0_data_strobes(m0_data_strobes), .m1_data_strobes(m1_data_strobes),
        .m0_read(m0_read), .m0_write(m0_write),
        .m1_read(m1_read), .m1_write(m1_write),
        .address(address), .data_out(data_out), .data_strobes(data_strobes),
        .read(read), .write(write), .data_in(data_in),
        .m0_data_in(m0_data_in), .m1_data_in(m1_data_in), .owner(owner)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_own  = 0;
        mdl_last = 1;
        mdl_held = 0;
    endtask

    task automatic model_edge(input logic r0, input logic r1);
        logic mine, other;
        if (mdl_own == 0) begin
            if (r0 && r1) mdl_own = (mdl_last == 1) ? 1 : 2;
            else if (r0)  mdl_own = 1;
            else if (r1)  mdl_own = 2;
            if (mdl_own != 0) begin
                mdl_last = mdl_own - 1;
                mdl_held = 1;
            end
        end else begin
            mine  = (mdl_own == 1) ? r0 : r1;
            other = (mdl_own == 1) ? r1 : r0;
            if (!mine || (PREEMPT && mdl_held >= MAX_TENURE && other)) begin
                mdl_own  = 0;
                mdl_held = 0;
            end else begin
                mdl_held = mdl_held + 1;
            end
        end
    endtask

    task automatic check_all();
        logic [29:0] e_addr;
        logic [31:0] e_dout;
        logic [3:0]  e_strb;
        logic        e_rd, e_wr;
        e_addr = '0; e_dout = '0; e_strb = '0; e_rd = 1'b0; e_wr = 1'b0;
        if (mdl_own == 1) begin
            e_addr = m0_address; e_dout = m0_data_out; e_strb = m0_data_strobes;
            e_rd = m0_read; e_wr = m0_write;
        end else if (mdl_own == 2) begin
            e_addr = m1_address; e_dout = m1_data_out; e_strb = m1_data_strobes;
            e_rd = m1_read; e_wr = m1_write;
        end
        chk("m0_grant", m0_grant, (mdl_own == 1) ? 1 : 0);
        chk("m1_grant", m1_grant, (mdl_own == 2) ? 1 : 0);
        chk("owner", owner, 32'(mdl_own));
        chk("grant_excl", m0_grant & m1_grant, 0);
        chk("address", address, e_addr);
        chk("data_out", data_out, e_dout);
        chk("strobes", data_strobes, e_strb);
        chk("read", read, e_rd);
        chk("write", write, e_wr);
        chk("m0_data_in", m0_data_in, data_in);
        chk("m1_data_in", m1_data_in, data_in);
    endtask

    // One clock edge: advance the model with the values sampled at the edge
    task automatic step();
        logic r0, r1, rs;
        r0 = m0_req; r1 = m1_req; rs = reset;
        @(posedge clock);
        if (!rs) model_reset();
        else     model_edge(r0, r1);
        #1;
        check_all();
    endtask

    initial begin
        int held;
        bit run;

        reset = 1'b0;
        m0_req = 1'b1; m1_req = 1'b0;
        m0_address = '0; m1_address = '0;
        m0_data_out = '0; m1_data_out = '0;
        m0_data_strobes = '0; m1_data_strobes = '0;
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        data_in = '0;

        // Reset held two cycles with m0 requesting
        step();
        step();
        chk("rst_owner", owner, 0);
        reset = 1'b1;
        step();
        chk("rst_release_grant", m0_grant, 1);

        // Single master m1 read; m0 read must not reach the bus
        m0_req = 1'b0;
        step();
        m1_req = 1'b1; m1_address = 30'h0000_0010; m1_read = 1'b1; m0_read = 1'b1;
        step();
        chk("single_owner", owner, 2'b10);
        chk("single_addr", address, 30'h10);
        chk("single_read", read, 1);

        // Data broadcast during the m1 read, same cycle
        data_in = 32'h1234_5678;
        #1;
        chk("bcast_m0", m0_data_in, 32'h1234_5678);
        chk("bcast_m1", m1_data_in, 32'h1234_5678);
        check_all();

        // Tie after a fresh reset goes to m0, then round robin to m1
        m1_req = 1'b0; m0_read = 1'b0; m1_read = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        step();
        reset = 1'b1;
        m0_req = 1'b1; m1_req = 1'b1; m0_read = 1'b1; m1_write = 1'b1;
        step();
        chk("tie_m0", m0_grant, 1);
        m0_req = 1'b0;
        step();
        chk("handover_idle_owner", owner, 0);
        chk("handover_idle_rw", {30'd0, read, write}, 0);
        step();
        chk("rr_m1", m1_grant, 1);
        m1_req = 1'b0;
        step();
        m0_req = 1'b1; m1_req = 1'b1;
        step();
        chk("rr_back_m0", m0_grant, 1);

        // Tenure: m0 owns, m1 keeps requesting
        m0_req = 1'b0; m1_req = 1'b0;
        step();
        m0_req = 1'b1;
        step();
        m1_req = 1'b1;
        held = 1; run = 1'b1;
        for (int i = 0; i < 19; i++) begin
            step();
            if (run && m0_grant) held = held + 1;
            else run = 1'b0;
        end
        chk("tenure_hold", held, PREEMPT ? MAX_TENURE : 20);

        // Reset mid-transfer: bus must clear without a clock edge
        m0_req = 1'b0; m1_req = 1'b0;
        step();
        step();
        m0_req = 1'b1; m0_write = 1'b1; m0_data_out = 32'hdead_beef; m0_address = 30'h123;
        step();
        chk("pre_rst_write", write, 1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("async_rst_write", write, 0);
        chk("async_rst_data", data_out, 0);
        check_all();
        step();
        chk("no_write_after_rst", write, 0);
        reset = 1'b1;
        m0_write = 1'b0;

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) m0_req = ~m0_req;
            if ($urandom_range(3) == 0) m1_req = ~m1_req;
            m0_address = 30'($urandom()); m1_address = 30'($urandom());
            m0_data_out = $urandom(); m1_data_out = $urandom();
            m0_data_strobes = 4'($urandom()); m1_data_strobes = 4'($urandom());
            m0_read = 1'($urandom()); m0_write = 1'($urandom());
            m1_read = 1'($urandom()); m1_write = 1'($urandom());
            data_in = $urandom();
            if ($urandom_range(63) == 0) begin
                reset = 1'b0;
                model_reset();
                #1;
                check_all();
            end else begin
                reset = 1'b1;
            end
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter for the maxicore32 system bus, sharing the single memory/peripheral bus (word address, data, strobes, read/write) between the CPU and a second master such as a DMA or debug engine. It sits between the masters and the address decoder. It grants ownership with a registered request/grant handshake and round-robin fairness. It muxes the owner's bus signals onto the shared bus and broadcasts read data back to both masters.

## Interface
Parameters:
- MAX_TENURE, 16, cycles a master may own the bus while the other is waiting before forced release; must be ≥ 2

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req, m1_req  in  1  bus request per master
- m0_grant, m1_grant  out  1  registered grant, at most one high
- m0_address, m1_address  in  30  word address [31:2]
- m0_data_out, m1_data_out  in  32  write data
- m0_data_strobes, m1_data_strobes  in  4  byte lane strobes
- m0_read, m0_write, m1_read, m1_write  in  1  cycle qualifiers
- address  out  30  shared bus address [31:2]
- data_out  out  32  shared write data
- data_strobes  out  4  shared strobes
- read, write  out  1  shared qualifiers
- data_in  in  32  read data from slaves
- m0_data_in, m1_data_in  out  32  copies of data_in, unconditional
- owner  out  2  2'b00 none, 2'b01 m0, 2'b10 m1

## Operation
- FSM states: IDLE, OWN0, OWN1. Reset state is IDLE.
- IDLE:
  - Shared bus outputs are all zero: address, data_out, strobes, read, write.
  - If only one master requests, go to that master's OWN state.
  - If both request, grant the master that is not last_owner.
  - last_owner resets to 1, so m0 wins the first tie.
- OWNx:
  - Shared outputs are combinationally muxed from master x, selected by the registered state.
  - m<x>_grant is high; owner reflects x.
  - last_owner is set to x on entry.
  - Masters may drive read/write only while their grant is high. A non-owner's read/write are ignored.
- Release: req<x> sampled low in OWNx → IDLE.
- Every change of owner passes through one IDLE cycle, so the bus is never driven by two masters on adjacent cycles.
- Tenure counter:
  - Width is $clog2(MAX_TENURE)+1.
  - Cleared on entry to OWNx and increments each cycle in OWNx.
  - Saturates at MAX_TENURE-1.
- Simultaneous events:
  - Release and forced release in the same cycle → IDLE; both outcomes are identical.
  - req toggling while in IDLE is re-evaluated every cycle.
- Grant and owner are never both high for m0 and m1; the bench asserts this every cycle.

## Timing
- Reset asserted (low), at any time including mid-transfer, immediately forces:
  - state IDLE, grants 0, owner 0, last_owner 1, counter 0
  - shared bus outputs zero
- Request latency: req sampled high at edge n in IDLE → grant high after edge n, i.e. visible in cycle n+1.
- Release latency: req low sampled at edge n → grant low after edge n.
- Handover: the other master's grant rises after edge n+1 at the earliest.
- data_in → m*_data_in is purely combinational, with zero latency.
- Memory read data for a cycle issued while granted is returned per the slave's own timing. The master keeps req high until it has captured data.

## Configuration
- BUS_ARBITER_PREEMPT_EN defined:
  - In OWNx, when the counter equals MAX_TENURE-1 and the other master's req is high, the FSM goes to IDLE at the next edge and m<x>_grant drops.
  - The round-robin rule in IDLE then grants the other master.
  - The preempted master must tolerate losing grant with req still high and re-arbitrates normally.
- Undefined:
  - No forced release; the counter logic is absent.
  - An owner keeps the bus until it drops req.

## Test plan
- Reset: hold reset low 2 cycles with m0_req=1 → grants 0, owner 2'b00, address/read/write 0. Release reset → m0_grant=1 one edge later.
- Single master: m1_req=1, m1_address=30'h0000_0010, m1_read=1 → next cycle owner=2'b10, address=30'h10, read=1. m0_read=1 on the same cycles does not reach the bus.
- Tie and round robin: both req from IDLE after reset → m0 granted. m0 drops req → one IDLE cycle with read=write=0, then m1 granted. Both request again after m1 releases → m0 granted.
- Preemption (macro on, MAX_TENURE=4): m0 owns and m1_req rises → m0_grant falls after 4th owned cycle, one IDLE cycle follows, then m1_grant=1. With the macro off, m0 keeps grant for 20 cycles.
- Reset mid-transfer: assert reset while owner=2'b01 and write=1, data_out=32'hdeadbeef → write and data_out go 0 immediately without waiting for a clock. No memory write occurs on the next edge.
- Data broadcast: data_in=32'h12345678 during an m1 read → m0_data_in and m1_data_in both equal 32'h12345678 in the same cycle.
